// File: rtl/smac_pkg.sv
// Shared types and pure helpers for the streaming signed multiply-accumulate.
package smac_pkg;

  localparam int unsigned MAXW = 64;

  typedef logic signed [MAXW-1:0] wide_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  typedef struct packed {
    logic signed [MAXW-1:0] val;
    logic                   clip;
  } sat_res_t;

  // Round half up, arithmetic shift, then clamp or wrap into owidth bits.
  function automatic sat_res_t sat_round(input logic signed [MAXW-1:0] value,
                                         input int unsigned shift,
                                         input int unsigned owidth,
                                         input bit saturate);
    wide_t    rnd;
    wide_t    r;
    wide_t    max_v;
    wide_t    min_v;
    sat_res_t res;
    rnd = '0;
    if (shift > 0) rnd = wide_t'(1) <<< (shift - 1);
    r        = (value + rnd) >>> shift;
    max_v    = (wide_t'(1) <<< (owidth - 1)) - wide_t'(1);
    min_v    = ~max_v;
    res.clip = (r > max_v) || (r < min_v);
    res.val  = r;
    if (res.clip && saturate) res.val = (r > max_v) ? max_v : min_v;
    return res;
  endfunction

  // Signed add overflow from the operand and sum sign bits.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/smac_prod_pipe.sv
// Full-precision product pipeline carrying valid/first/last, frozen while en_i is low.
module smac_prod_pipe #(
  parameter int unsigned AWIDTH   = 8,
  parameter int unsigned BWIDTH   = 8,
  parameter int unsigned PIPELINE = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en_i,
  input  logic                             valid_i,
  input  logic                             first_i,
  input  logic                             last_i,
  input  logic signed [AWIDTH-1:0]         a_i,
  input  logic signed [BWIDTH-1:0]         b_i,
  output logic                             valid_o,
  output logic                             first_o,
  output logic                             last_o,
  output logic signed [AWIDTH+BWIDTH-1:0]  prod_o
);

  localparam int unsigned PW = AWIDTH + BWIDTH;

  if (PIPELINE == 0 || PIPELINE > 4) begin : g_bad_cfg
    $fatal(1, "smac_prod_pipe: PIPELINE must be 1..4");
  end

  logic [PIPELINE-1:0]   vld_q;
  logic [PIPELINE-1:0]   fst_q;
  logic [PIPELINE-1:0]   lst_q;
  logic signed [PW-1:0]  prod_q [PIPELINE];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (en_i) begin
      vld_q[0] <= valid_i;
      for (int i = 1; i < PIPELINE; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Payload needs no reset; it is qualified by the valid chain.
  always_ff @(posedge clk) begin
    if (en_i) begin
      fst_q[0]  <= first_i;
      lst_q[0]  <= last_i;
      prod_q[0] <= PW'(a_i) * PW'(b_i);
      for (int i = 1; i < PIPELINE; i++) begin
        fst_q[i]  <= fst_q[i-1];
        lst_q[i]  <= lst_q[i-1];
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[PIPELINE-1];
  assign first_o = fst_q[PIPELINE-1];
  assign last_o  = lst_q[PIPELINE-1];
  assign prod_o  = prod_q[PIPELINE-1];

endmodule

// File: rtl/smac_stream.sv
// Streaming signed MAC: pipelined product, per-packet accumulate, rounded/saturated
// result held in a single-entry output register with valid/ready backpressure.
module smac_stream
  import smac_pkg::*;
#(
  parameter int unsigned AWIDTH   = 8,
  parameter int unsigned BWIDTH   = 8,
  parameter int unsigned PIPELINE = 2,
  parameter int unsigned ACCWIDTH = 32,
  parameter int unsigned OWIDTH   = 16,
  parameter int unsigned SHIFT    = 0,
  parameter int unsigned SATURATE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [AWIDTH-1:0] a,
  input  logic signed [BWIDTH-1:0] b,
  input  logic                     first,
  input  logic                     last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OWIDTH-1:0] out,
  output logic                     out_ovf
);

  localparam int unsigned PW = AWIDTH + BWIDTH;

  if (PIPELINE == 0 || PIPELINE > 4 || ACCWIDTH < PW || OWIDTH > ACCWIDTH
      || ACCWIDTH >= MAXW) begin : g_bad_cfg
    $fatal(1, "smac_stream: illegal PIPELINE/ACCWIDTH/OWIDTH combination");
  end

  logic                       adv;
  logic                       pv;
  logic                       pf;
  logic                       pl;
  logic signed [PW-1:0]       prod;
  logic signed [ACCWIDTH-1:0] acc_q, acc_d;
  logic signed [ACCWIDTH-1:0] base;
  logic signed [ACCWIDTH-1:0] prod_ext;
  logic signed [ACCWIDTH-1:0] sum;
  logic                       sticky_q, sticky_d;
  logic                       sticky_new;
  logic                       take;
  logic                       take_last;
  out_state_e                 state_q, state_d;
  logic signed [OWIDTH-1:0]   out_q, out_d;
  logic                       ovf_q, ovf_d;
  sat_res_t                   sr;
  logic                       unused_sr_hi;

  // The whole datapath freezes only while a result is waiting to be taken.
  assign adv       = !((state_q == FULL) && !out_ready);
  assign in_ready  = !rst && adv;
  assign out_valid = (state_q == FULL);
  assign out       = out_q;
  assign out_ovf   = ovf_q;

  smac_prod_pipe #(
    .AWIDTH  (AWIDTH),
    .BWIDTH  (BWIDTH),
    .PIPELINE(PIPELINE)
  ) u_prod_pipe (
    .clk    (clk),
    .rst    (rst),
    .en_i   (adv),
    .valid_i(in_valid && in_ready),
    .first_i(first),
    .last_i (last),
    .a_i    (a),
    .b_i    (b),
    .valid_o(pv),
    .first_o(pf),
    .last_o (pl),
    .prod_o (prod)
  );

  always_comb begin
    acc_d      = acc_q;
    sticky_d   = sticky_q;
    state_d    = state_q;
    out_d      = out_q;
    ovf_d      = ovf_q;
    take       = adv && pv;
    take_last  = take && pl;
    base       = pf ? '0 : acc_q;
    prod_ext   = ACCWIDTH'(prod);
    sum        = base + prod_ext;
    sticky_new = (!pf && sticky_q)
               || add_ovf(base[ACCWIDTH-1], prod_ext[ACCWIDTH-1], sum[ACCWIDTH-1]);
    sr         = sat_round(MAXW'(sum), SHIFT, OWIDTH, SATURATE != 0);

    if (take) begin
      acc_d    = sum;
      sticky_d = sticky_new;
    end
    // A finished packet leaves a clean accumulator for a headless next packet.
    if (take_last) begin
      acc_d    = '0;
      sticky_d = 1'b0;
      out_d    = OWIDTH'(sr.val);
      ovf_d    = sticky_new || sr.clip;
    end

    case (state_q)
      EMPTY:   if (take_last) state_d = FULL;
      FULL:    if (out_ready && !take_last) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  assign unused_sr_hi = ^sr.val[MAXW-1:OWIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
      state_q  <= EMPTY;
      out_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      state_q  <= state_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
